// File: rtl/semaforo_monitor.sv
// semaforo_monitor
// Passive checker on the lamp side of the traffic-light controller. It decodes
// the lit phase, measures how long each phase lasts, raises sticky fault flags
// for illegal lamp patterns, illegal phase order or wrong phase durations, and
// counts completed RED->YELLOW->GREEN cycles. It drives nothing back.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   enable       controller enable (same net as the controller sees)
//   red/yellow/green  lamp inputs
//   clear        synchronous clear of sticky flags and cycle_count
//   phase        decoded phase: 0 OFF, 1 RED, 2 YELLOW, 3 GREEN
//   err_onehot   sticky: more than one lamp lit
//   err_seq      sticky: illegal phase order or lamp/enable mismatch
//   err_time     sticky: phase shorter or longer than required
//   fault        OR of the three error flags
//   cycle_count  completed GREEN->RED transitions (wraps)
//   last_len     length of the most recently ended phase (saturating)
module semaforo_monitor #(
    parameter int RED_CYC = 51,
    parameter int YEL_CYC = 11,
    parameter int GRN_CYC = 41,
    parameter int LEN_W   = 8,
    parameter int CYC_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             red,
    input  logic             yellow,
    input  logic             green,
    input  logic             clear,
    output logic [1:0]       phase,
    output logic             err_onehot,
    output logic             err_seq,
    output logic             err_time,
    output logic             fault,
    output logic [CYC_W-1:0] cycle_count,
    output logic [LEN_W-1:0] last_len
);

    localparam logic [2:0] LAMP_OFF = 3'b000;
    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
        return (v == {LEN_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    function automatic logic [LEN_W-1:0] exp_len(input logic [2:0] p);
        case (p)
            LAMP_RED: return LEN_W'(RED_CYC);
            LAMP_YEL: return LEN_W'(YEL_CYC);
            LAMP_GRN: return LEN_W'(GRN_CYC);
            default:  return '0;
        endcase
    endfunction

    function automatic logic [1:0] decode(input logic [2:0] p);
        case (p)
            LAMP_RED: return 2'd1;
            LAMP_YEL: return 2'd2;
            LAMP_GRN: return 2'd3;
            default:  return 2'd0;
        endcase
    endfunction

    function automatic logic legal_step(input logic [2:0] from, input logic [2:0] to);
        return (to == LAMP_OFF) ||
               (from == LAMP_OFF && to == LAMP_RED) ||
               (from == LAMP_RED && to == LAMP_YEL) ||
               (from == LAMP_YEL && to == LAMP_GRN) ||
               (from == LAMP_GRN && to == LAMP_RED);
    endfunction

    logic [2:0]       lamps;
    logic [2:0]       lamp_q;
    logic [LEN_W-1:0] run_len;
    logic             en_q;

    logic             multi;
    logic             seq_bad;
    logic             time_bad;
    logic             grn_to_red;
    logic [2:0]       lamp_d;
    logic [LEN_W-1:0] run_d;
    logic [LEN_W-1:0] last_d;
    logic [1:0]       phase_d;

    assign lamps = {red, yellow, green};

    // Sample evaluation: a multi-lamp sample only flags err_onehot and is
    // otherwise invisible to the phase tracker.
    always_comb begin
        multi      = ($countones(lamps) > 1);
        lamp_d     = lamp_q;
        run_d      = run_len;
        last_d     = last_len;
        phase_d    = phase;
        seq_bad    = 1'b0;
        time_bad   = 1'b0;
        grn_to_red = 1'b0;
        if (!multi) begin
            phase_d = decode(lamps);
            if (lamps == lamp_q) begin
                run_d = sat_inc(run_len);
                // Fires on the first sample beyond the required length.
                if (lamps != LAMP_OFF && run_len == exp_len(lamps))
                    time_bad = 1'b1;
            end else begin
                run_d  = LEN_W'(1);
                last_d = run_len;
                lamp_d = lamps;
                if (!legal_step(lamp_q, lamps))
                    seq_bad = 1'b1;
                // Dropping to OFF is a legal truncation and is not timed.
                if (lamps != LAMP_OFF && lamp_q != LAMP_OFF && run_len < exp_len(lamp_q))
                    time_bad = 1'b1;
                grn_to_red = (lamp_q == LAMP_GRN) && (lamps == LAMP_RED);
            end
            // One lit cycle after enable falls is tolerated because en_q is still 1.
            if (lamps != LAMP_OFF && !en_q)
                seq_bad = 1'b1;
            // Only the first sample after enable rises may be dark.
            if (lamps == LAMP_OFF && enable && en_q)
                seq_bad = 1'b1;
        end
    end

    // State update: new errors take priority over a coincident clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase       <= '0;
            err_onehot  <= 1'b0;
            err_seq     <= 1'b0;
            err_time    <= 1'b0;
            cycle_count <= '0;
            last_len    <= '0;
            lamp_q      <= LAMP_OFF;
            run_len     <= '0;
            en_q        <= 1'b0;
        end else begin
            en_q       <= enable;
            lamp_q     <= lamp_d;
            run_len    <= run_d;
            last_len   <= last_d;
            phase      <= phase_d;
            err_onehot <= (err_onehot & ~clear) | multi;
            err_seq    <= (err_seq & ~clear) | seq_bad;
            err_time   <= (err_time & ~clear) | time_bad;
            if (clear)
                cycle_count <= '0;
            else if (grn_to_red)
                cycle_count <= cycle_count + 1'b1;
        end
    end

    assign fault = err_onehot | err_seq | err_time;

endmodule

// File: tb/tb_semaforo_monitor.sv
module tb_semaforo_monitor;

    localparam int RED_CYC = 51;
    localparam int YEL_CYC = 11;
    localparam int GRN_CYC = 41;
    localparam int LEN_W   = 8;
    localparam int CYC_W   = 16;

    localparam logic [2:0] L0 = 3'b000;
    localparam logic [2:0] LR = 3'b100;
    localparam logic [2:0] LY = 3'b010;
    localparam logic [2:0] LG = 3'b001;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             enable = 1'b0;
    logic             red = 1'b0;
    logic             yellow = 1'b0;
    logic             green = 1'b0;
    logic             clear = 1'b0;
    logic [1:0]       phase;
    logic             err_onehot;
    logic             err_seq;
    logic             err_time;
    logic             fault;
    logic [CYC_W-1:0] cycle_count;
    logic [LEN_W-1:0] last_len;

    semaforo_monitor #(
        .RED_CYC(RED_CYC), .YEL_CYC(YEL_CYC), .GRN_CYC(GRN_CYC),
        .LEN_W(LEN_W), .CYC_W(CYC_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .red(red), .yellow(yellow),
        .green(green), .clear(clear), .phase(phase), .err_onehot(err_onehot),
        .err_seq(err_seq), .err_time(err_time), .fault(fault),
        .cycle_count(cycle_count), .last_len(last_len)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // One stimulus segment: hold inputs for n cycles, then check outputs.
    // rst marks a reset row; last < 0 means last_len is not checked.
    typedef struct {
        bit         rst;
        int         n;
        logic [2:0] lamps;
        bit         en;
        bit         clr;
        int         ph;
        logic [2:0] fl;   // {err_onehot, err_seq, err_time}
        int         cnt;
        int         last;
    } row_t;

    function automatic row_t mk(bit rst, int n, logic [2:0] l, bit en, bit clr,
                                int ph, logic [2:0] fl, int cnt, int last);
        row_t r;
        r.rst = rst; r.n = n; r.lamps = l; r.en = en; r.clr = clr;
        r.ph = ph; r.fl = fl; r.cnt = cnt; r.last = last;
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act != exp)
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic drive(input logic [2:0] l, input bit en, input bit clr);
        {red, yellow, green} = l;
        enable = en;
        clear  = clr;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        drive(L0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_out(input string tag, input int ph, input logic [2:0] fl,
                             input int cnt, input int last);
        chk({tag, " phase"}, int'(phase), ph);
        chk({tag, " flags"}, int'({err_onehot, err_seq, err_time}), int'(fl));
        chk({tag, " fault"}, int'(fault), int'(|fl));
        chk({tag, " cycle_count"}, int'(cycle_count), cnt);
        if (last >= 0)
            chk({tag, " last_len"}, int'(last_len), last);
    endtask

    task automatic seg(input string tag, input row_t r);
        for (int i = 0; i < r.n; i++) begin
            drive(r.lamps, r.en, r.clr);
            tick();
        end
        check_out(tag, r.ph, r.fl, r.cnt, r.last);
    endtask

    // Behavioural reference: phases as numbers 0..3, lengths as plain ints.
    int EXPT[4] = '{0, RED_CYC, YEL_CYC, GRN_CYC};
    int NXT[4]  = '{1, 2, 3, 1};
    int m_ph, m_run, m_last, m_cnt, m_oph;
    bit m_enq, m_eo, m_es, m_et;

    task automatic m_init;
        m_ph = 0; m_run = 0; m_last = 0; m_cnt = 0; m_oph = 0;
        m_enq = 0; m_eo = 0; m_es = 0; m_et = 0;
    endtask

    task automatic m_step(input logic [2:0] l, input bit en, input bit clr);
        bit eo, es, et;
        int p;
        eo = 0; es = 0; et = 0;
        if ($countones(l) > 1) begin
            eo = 1;
        end else begin
            p = (l == LR) ? 1 : (l == LY) ? 2 : (l == LG) ? 3 : 0;
            if (p == m_ph) begin
                if (p != 0 && m_run == EXPT[p]) et = 1;
                m_run++;
            end else begin
                if (p != 0 && p != NXT[m_ph]) es = 1;
                if (p != 0 && m_ph != 0 && m_run < EXPT[m_ph]) et = 1;
                if (m_ph == 3 && p == 1) m_cnt = (m_cnt + 1) % (1 << CYC_W);
                m_last = m_run;
                m_run  = 1;
                m_ph   = p;
            end
            if (p != 0 && !m_enq) es = 1;
            if (p == 0 && en && m_enq) es = 1;
            m_oph = p;
        end
        m_enq = en;
        m_eo = eo | (m_eo & !clr);
        m_es = es | (m_es & !clr);
        m_et = et | (m_et & !clr);
        if (clr) m_cnt = 0;
    endtask

    function automatic int sat(input int v);
        return (v > (1 << LEN_W) - 1) ? (1 << LEN_W) - 1 : v;
    endfunction

    function automatic logic [2:0] pat(input int p);
        case (p)
            1: return LR;
            2: return LY;
            3: return LG;
            default: return L0;
        endcase
    endfunction

    function automatic int dur(input int p);
        int d;
        int r;
        d = EXPT[p];
        r = int'($urandom_range(0, 15));
        if (r == 0)
            d = int'($urandom_range(1, 70));
        else if (r < 3)
            d = d + (($urandom_range(0, 1) == 1) ? 1 : -1);
        return d;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    row_t rows[$];

    initial begin
        int  g_ph, g_left;
        bit  g_en, en_r, clr_r;
        logic [2:0] l_r;

        // Ideal controller, two full cycles
        rows.push_back(mk(1, 0, L0, 0, 0, 0, 3'b000, 0, -1));
        rows.push_back(mk(0, 1, L0, 1, 0, 0, 3'b000, 0, -1));
        rows.push_back(mk(0, 51, LR, 1, 0, 1, 3'b000, 0, 1));
        rows.push_back(mk(0, 11, LY, 1, 0, 2, 3'b000, 0, 51));
        rows.push_back(mk(0, 41, LG, 1, 0, 3, 3'b000, 0, 11));
        rows.push_back(mk(0, 51, LR, 1, 0, 1, 3'b000, 1, 41));
        rows.push_back(mk(0, 11, LY, 1, 0, 2, 3'b000, 1, 51));
        rows.push_back(mk(0, 41, LG, 1, 0, 3, 3'b000, 1, 11));
        rows.push_back(mk(0, 1, LR, 1, 0, 1, 3'b000, 2, 41));
        // RED overrun on the 52nd sample
        rows.push_back(mk(1, 0, L0, 0, 0, 0, 3'b000, 0, -1));
        rows.push_back(mk(0, 1, L0, 1, 0, 0, 3'b000, 0, -1));
        rows.push_back(mk(0, 51, LR, 1, 0, 1, 3'b000, 0, 1));
        rows.push_back(mk(0, 1, LR, 1, 0, 1, 3'b001, 0, 1));
        // YELLOW underrun
        rows.push_back(mk(1, 0, L0, 0, 0, 0, 3'b000, 0, -1));
        rows.push_back(mk(0, 1, L0, 1, 0, 0, 3'b000, 0, -1));
        rows.push_back(mk(0, 51, LR, 1, 0, 1, 3'b000, 0, 1));
        rows.push_back(mk(0, 10, LY, 1, 0, 2, 3'b000, 0, 51));
        rows.push_back(mk(0, 1, LG, 1, 0, 3, 3'b001, 0, 10));
        // RED -> GREEN directly
        rows.push_back(mk(1, 0, L0, 0, 0, 0, 3'b000, 0, -1));
        rows.push_back(mk(0, 1, L0, 1, 0, 0, 3'b000, 0, -1));
        rows.push_back(mk(0, 51, LR, 1, 0, 1, 3'b000, 0, 1));
        rows.push_back(mk(0, 1, LG, 1, 0, 3, 3'b010, 0, 51));
        // Two lamps lit, phase holds
        rows.push_back(mk(1, 0, L0, 0, 0, 0, 3'b000, 0, -1));
        rows.push_back(mk(0, 1, L0, 1, 0, 0, 3'b000, 0, -1));
        rows.push_back(mk(0, 5, LR, 1, 0, 1, 3'b000, 0, 1));
        rows.push_back(mk(0, 1, 3'b101, 1, 0, 1, 3'b100, 0, 1));
        // Enable dropped mid-GREEN, lamps off one cycle later
        rows.push_back(mk(1, 0, L0, 0, 0, 0, 3'b000, 0, -1));
        rows.push_back(mk(0, 1, L0, 1, 0, 0, 3'b000, 0, -1));
        rows.push_back(mk(0, 51, LR, 1, 0, 1, 3'b000, 0, 1));
        rows.push_back(mk(0, 11, LY, 1, 0, 2, 3'b000, 0, 51));
        rows.push_back(mk(0, 20, LG, 1, 0, 3, 3'b000, 0, 11));
        rows.push_back(mk(0, 1, LG, 0, 0, 3, 3'b000, 0, 11));
        rows.push_back(mk(0, 1, L0, 0, 0, 0, 3'b000, 0, 21));
        rows.push_back(mk(0, 3, L0, 0, 0, 0, 3'b000, 0, 21));
        // Lamp still lit two cycles after enable falls
        rows.push_back(mk(1, 0, L0, 0, 0, 0, 3'b000, 0, -1));
        rows.push_back(mk(0, 1, L0, 1, 0, 0, 3'b000, 0, -1));
        rows.push_back(mk(0, 5, LR, 1, 0, 1, 3'b000, 0, 1));
        rows.push_back(mk(0, 1, LR, 0, 0, 1, 3'b000, 0, 1));
        rows.push_back(mk(0, 1, LR, 0, 0, 1, 3'b010, 0, 1));
        // Two dark samples with enable high
        rows.push_back(mk(1, 0, L0, 0, 0, 0, 3'b000, 0, -1));
        rows.push_back(mk(0, 1, L0, 1, 0, 0, 3'b000, 0, -1));
        rows.push_back(mk(0, 1, L0, 1, 0, 0, 3'b010, 0, -1));
        // Clear after errors, then clear coincident with an overrun
        rows.push_back(mk(1, 0, L0, 0, 0, 0, 3'b000, 0, -1));
        rows.push_back(mk(0, 1, L0, 1, 0, 0, 3'b000, 0, -1));
        rows.push_back(mk(0, 51, LR, 1, 0, 1, 3'b000, 0, 1));
        rows.push_back(mk(0, 11, LY, 1, 0, 2, 3'b000, 0, 51));
        rows.push_back(mk(0, 41, LG, 1, 0, 3, 3'b000, 0, 11));
        rows.push_back(mk(0, 1, LR, 1, 0, 1, 3'b000, 1, 41));
        rows.push_back(mk(0, 1, LG, 1, 0, 3, 3'b011, 1, 1));
        rows.push_back(mk(0, 1, LG, 1, 1, 3, 3'b000, 0, 1));
        rows.push_back(mk(0, 39, LG, 1, 0, 3, 3'b000, 0, 1));
        rows.push_back(mk(0, 1, LG, 1, 1, 3, 3'b001, 0, 1));

        check_out("reset", 0, 3'b000, 0, 0);
        foreach (rows[i]) begin
            if (rows[i].rst)
                do_reset();
            else
                seg($sformatf("row%0d", i), rows[i]);
        end

        // Asynchronous reset mid-YELLOW with a flag set, then a clean cycle
        do_reset();
        seg("ar_off", mk(0, 1, L0, 1, 0, 0, 3'b000, 0, -1));
        seg("ar_r1", mk(0, 51, LR, 1, 0, 1, 3'b000, 0, 1));
        seg("ar_y1", mk(0, 11, LY, 1, 0, 2, 3'b000, 0, 51));
        seg("ar_g1", mk(0, 41, LG, 1, 0, 3, 3'b000, 0, 11));
        seg("ar_r2", mk(0, 51, LR, 1, 0, 1, 3'b000, 1, 41));
        seg("ar_y2", mk(0, 5, LY, 1, 0, 2, 3'b000, 1, 51));
        seg("ar_bad", mk(0, 1, 3'b011, 1, 0, 2, 3'b100, 1, 51));
        seg("ar_y3", mk(0, 1, LY, 1, 0, 2, 3'b100, 1, 51));
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_rst", 0, 3'b000, 0, 0);
        drive(L0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        seg("post_off", mk(0, 1, L0, 1, 0, 0, 3'b000, 0, -1));
        seg("post_r", mk(0, 51, LR, 1, 0, 1, 3'b000, 0, 1));
        seg("post_y", mk(0, 11, LY, 1, 0, 2, 3'b000, 0, 51));
        seg("post_g", mk(0, 41, LG, 1, 0, 3, 3'b000, 0, 11));
        seg("post_r2", mk(0, 1, LR, 1, 0, 1, 3'b000, 1, 41));

        // Randomized controller with perturbations against the reference model
        do_reset();
        m_init();
        g_ph = 0; g_left = 0; g_en = 0;
        for (int c = 0; c < 5000; c++) begin
            if (g_left <= 0) begin
                if (!g_en) begin
                    g_en = 1; g_ph = 0; g_left = 1;
                end else if ($urandom_range(0, 9) == 0) begin
                    g_en = 0; g_ph = 0; g_left = int'($urandom_range(1, 300));
                end else begin
                    g_ph = (g_ph == 0 || g_ph == 3) ? 1 : g_ph + 1;
                    g_left = dur(g_ph);
                end
            end
            g_left--;
            l_r   = pat(g_ph);
            en_r  = g_en;
            clr_r = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 39) == 0) l_r = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 59) == 0) en_r = !en_r;
            drive(l_r, en_r, clr_r);
            m_step(l_r, en_r, clr_r);
            tick();
            chk("rnd phase", int'(phase), m_oph);
            chk("rnd flags", int'({err_onehot, err_seq, err_time}), int'({m_eo, m_es, m_et}));
            chk("rnd fault", int'(fault), int'(m_eo | m_es | m_et));
            chk("rnd cycle_count", int'(cycle_count), m_cnt);
            chk("rnd last_len", int'(last_len), sat(m_last));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/semaforo_monitor.md
Name: semaforo_monitor

Overview:
- Passive checker on the lamp side of the traffic-light controller. Observes enable, red, yellow and green.
- Decodes the current phase and measures how long each phase lasts.
- Raises sticky fault flags for illegal lamp patterns, illegal phase order or wrong phase durations, and counts completed RED->YELLOW->GREEN cycles.
- Sits beside the controller in the top level and the testbench; it drives nothing back into the controller.

Parameters:
RED_CYC, 51, required RED duration in clock cycles
YEL_CYC, 11, required YELLOW duration in clock cycles
GRN_CYC, 41, required GREEN duration in clock cycles
LEN_W, 8, width of the run-length counter and last_len (saturating)
CYC_W, 16, width of cycle_count (wraps)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
enable  input  1  same enable that drives the controller
red  input  1  red lamp
yellow  input  1  yellow lamp
green  input  1  green lamp
clear  input  1  synchronous clear of sticky flags and cycle_count
phase  output  2  decoded phase: 0 OFF, 1 RED, 2 YELLOW, 3 GREEN
err_onehot  output  1  sticky: more than one lamp lit
err_seq  output  1  sticky: illegal phase order or lamp/enable mismatch
err_time  output  1  sticky: phase shorter or longer than its parameter
fault  output  1  OR of the three error flags
cycle_count  output  CYC_W  completed GREEN->RED transitions
last_len  output  LEN_W  length of the most recently ended phase

Behaviour:
- One clock; reset is asynchronous and active-low (rst_n).
- On reset, all of the following are 0: phase, err_*, fault, cycle_count, last_len, the internal lamp register lamp_q, run_len and en_q.
- Sampling: every rising edge samples {red, yellow, green, enable}. All outputs are registered and update at that same edge, so a violation present on the inputs before edge k is visible after edge k. fault is a combinational OR of the flag registers.
- Phase decode:
  - 000 -> OFF; 100 -> RED; 010 -> YELLOW; 001 -> GREEN.
  - Any pattern with two or more lamps lit sets err_onehot. phase holds its previous value. lamp_q and run_len are not updated; that sample is ignored for sequence and timing checks.
- Run length: run_len counts consecutive samples of the pattern held in lamp_q, saturating at 2^LEN_W-1.
  - Same legal pattern sampled again: run_len increments.
  - Pattern changes: run_len becomes 1, last_len takes the old run_len, and lamp_q takes the new pattern.
- Legal transitions: OFF->RED, RED->YELLOW, YELLOW->GREEN, GREEN->RED, any->OFF. Any other change sets err_seq.
- Timing checks (EXP(P) = RED_CYC, YEL_CYC or GRN_CYC for the lit phase P):
  - Overrun: the same lit pattern P is sampled while run_len == EXP(P) -> set err_time. It fires at the first extra cycle; run_len keeps counting.
  - Underrun: P changes to another lit phase while run_len < EXP(P) -> set err_time.
  - A change to OFF (enable dropped) is a legal truncation: no timing check.
  - The first RED after OFF is timed normally.
- Enable consistency (en_q = enable at the previous sample):
  - Lamp lit while en_q == 0 -> err_seq. The single cycle in which enable has just fallen and the lamp is still lit passes, because en_q is 1.
  - Lamps 000 with enable == 1 and en_q == 1 -> err_seq. Only one OFF cycle is allowed after enable rises.
- cycle_count increments by 1 on each legal GREEN->RED change and wraps modulo 2^CYC_W.
- Flags are sticky until clear or reset.
  - clear zeroes err_*, and cycle_count at the next edge.
  - clear leaves phase, run_len, last_len and lamp_q untouched.
  - clear and a new error in the same cycle: the error wins and the flag is 1 after the edge.
- Reset mid-phase: all state returns to its reset value. The monitor restarts at OFF with run_len 0, so the next RED is timed from its first sample.

Test Plan:
1. Enable high, ideal controller for 2 full cycles (RED 51, YELLOW 11, GREEN 41) -> no flags. cycle_count = 2 after the second GREEN->RED. last_len = 41 right after that change. phase sequence 0,1,2,3,1,...
2. Hold RED for 52 cycles -> err_time rises at the edge sampling the 52nd RED cycle. fault = 1. phase stays 1.
3. YELLOW ends after 10 cycles into GREEN -> err_time at the edge sampling the first GREEN; last_len = 10. Separately, RED->GREEN directly -> err_seq. Separately, red and green both high for one cycle -> err_onehot, and phase holds 1.
4. Enable dropped mid-GREEN at run_len 20, lamps off one cycle later -> no flags and phase = 0. A lamp still lit 2 cycles after enable falls -> err_seq. Enable high with lamps 000 for 2 samples -> err_seq.
5. Errors set, then clear pulsed for 1 cycle -> all err_*, fault and cycle_count read 0 next cycle. clear coincident with an overrun sample -> err_time = 1.
6. rst_n asserted asynchronously mid-YELLOW -> all outputs 0 immediately. After release, a full legal cycle raises no flags.
